// File: rtl/l1_l2_arbiter.sv
// Round-robin arbiter sharing the single L2 request port between L1I and L1D.
// One transaction is latched per grant and held stable until L2 signals ready.
module l1_l2_arbiter #(
    parameter int unsigned TAG_W   = 22,
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned CNT_W   = 11
) (
    input  logic             clk,
    input  logic             nrst,
    // L1I refill side
    input  logic             read_L1I_L2,
    input  logic [TAG_W-1:0] tag_L1I_L2,
    input  logic [IDX_W-1:0] index_L1I_L2,
    output logic             ready_L2_L1I,
    // L1D refill / write-back side
    input  logic             read_L1D_L2,
    input  logic             write_L1D_L2,
    input  logic [TAG_W-1:0] tag_L1D_L2,
    input  logic [IDX_W-1:0] index_L1D_L2,
    input  logic [TAG_W-1:0] write_tag_L1D_L2,
    input  logic [IDX_W-1:0] write_index_L1D_L2,
    output logic             ready_L2_L1D,
    // L2 side
    output logic             read_L1_L2,
    output logic             write_L1_L2,
    output logic [TAG_W-1:0] tag_L1_L2,
    output logic [IDX_W-1:0] index_L1_L2,
    input  logic             ready_L2_L1,
    // status
    output logic [1:0]       grant_o,
    output logic             timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

    state_e             state_q, state_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic [1:0]         grant_q, grant_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_d_q, last_d_d;   // 1: L1D owned the last grant

    logic req_i;
    logic req_d;
    logic pick_d;

    assign req_i  = read_L1I_L2;
    assign req_d  = read_L1D_L2 | write_L1D_L2;
    // L1D wins when alone, or on a tie when L1I was served last
    assign pick_d = req_d & (~req_i | ~last_d_q);

    // State and registered outputs
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= IDLE;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            tag_q     <= '0;
            index_q   <= '0;
            grant_q   <= 2'b00;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            last_d_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            read_q    <= read_d;
            write_q   <= write_d;
            tag_q     <= tag_d;
            index_q   <= index_d;
            grant_q   <= grant_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
            last_d_q  <= last_d_d;
        end
    end

    // Grant selection, transaction latch, completion and wait counting
    always_comb begin
        state_d   = state_q;
        read_d    = read_q;
        write_d   = write_q;
        tag_d     = tag_q;
        index_d   = index_q;
        grant_d   = grant_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        last_d_d  = last_d_q;

        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    state_d = GNT_D;
                    grant_d = 2'b10;
                    cnt_d   = '0;
                    if (write_L1D_L2) begin
                        // write-back first; a pending refill gets its own grant later
                        write_d = 1'b1;
                        read_d  = 1'b0;
                        tag_d   = write_tag_L1D_L2;
                        index_d = write_index_L1D_L2;
                    end else begin
                        write_d = 1'b0;
                        read_d  = 1'b1;
                        tag_d   = tag_L1D_L2;
                        index_d = index_L1D_L2;
                    end
                end else if (req_i) begin
                    state_d = GNT_I;
                    grant_d = 2'b01;
                    cnt_d   = '0;
                    write_d = 1'b0;
                    read_d  = 1'b1;
                    tag_d   = tag_L1I_L2;
                    index_d = index_L1I_L2;
                end
            end
            GNT_I, GNT_D: begin
                if (ready_L2_L1) begin
                    state_d  = IDLE;
                    read_d   = 1'b0;
                    write_d  = 1'b0;
                    grant_d  = 2'b00;
                    cnt_d    = '0;
                    last_d_d = (state_q == GNT_D);
                end else begin
                    if (cnt_q != TIMEOUT_CNT) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_d == TIMEOUT_CNT) begin
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
                grant_d = 2'b00;
            end
        endcase
    end

    // Ready is routed to the current owner only, in the same cycle
    assign ready_L2_L1I = ready_L2_L1 & (state_q == GNT_I);
    assign ready_L2_L1D = ready_L2_L1 & (state_q == GNT_D);

    assign read_L1_L2  = read_q;
    assign write_L1_L2 = write_q;
    assign tag_L1_L2   = tag_q;
    assign index_L1_L2 = index_q;
    assign grant_o     = grant_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_l1_l2_arbiter.sv
// Self-checking bench for l1_l2_arbiter with a transaction scoreboard.
module tb_l1_l2_arbiter;

    localparam int unsigned TAG_W   = 22;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned TIMEOUT = 8;
    localparam int unsigned CNT_W   = 4;

    typedef struct packed {
        logic             wr;
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [1:0]       grant;
    } txn_t;

    logic             clk = 1'b0;
    logic             nrst = 1'b0;
    logic             read_L1I_L2 = 1'b0;
    logic [TAG_W-1:0] tag_L1I_L2 = '0;
    logic [IDX_W-1:0] index_L1I_L2 = '0;
    logic             ready_L2_L1I;
    logic             read_L1D_L2 = 1'b0;
    logic             write_L1D_L2 = 1'b0;
    logic [TAG_W-1:0] tag_L1D_L2 = '0;
    logic [IDX_W-1:0] index_L1D_L2 = '0;
    logic [TAG_W-1:0] write_tag_L1D_L2 = '0;
    logic [IDX_W-1:0] write_index_L1D_L2 = '0;
    logic             ready_L2_L1D;
    logic             read_L1_L2;
    logic             write_L1_L2;
    logic [TAG_W-1:0] tag_L1_L2;
    logic [IDX_W-1:0] index_L1_L2;
    logic             ready_L2_L1 = 1'b0;
    logic [1:0]       grant_o;
    logic             timeout_o;

    int   n_tests = 0;
    int   n_fail  = 0;
    txn_t exp_q[$];

    l1_l2_arbiter #(
        .TAG_W  (TAG_W),
        .IDX_W  (IDX_W),
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) dut (
        .clk               (clk),
        .nrst              (nrst),
        .read_L1I_L2       (read_L1I_L2),
        .tag_L1I_L2        (tag_L1I_L2),
        .index_L1I_L2      (index_L1I_L2),
        .ready_L2_L1I      (ready_L2_L1I),
        .read_L1D_L2       (read_L1D_L2),
        .write_L1D_L2      (write_L1D_L2),
        .tag_L1D_L2        (tag_L1D_L2),
        .index_L1D_L2      (index_L1D_L2),
        .write_tag_L1D_L2  (write_tag_L1D_L2),
        .write_index_L1D_L2(write_index_L1D_L2),
        .ready_L2_L1D      (ready_L2_L1D),
        .read_L1_L2        (read_L1_L2),
        .write_L1_L2       (write_L1_L2),
        .tag_L1_L2         (tag_L1_L2),
        .index_L1_L2       (index_L1_L2),
        .ready_L2_L1       (ready_L2_L1),
        .grant_o           (grant_o),
        .timeout_o         (timeout_o)
    );

    always #5 clk = ~clk;

    // Hard stop if something hangs
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic txn_t cur_txn();
        txn_t t;
        t.wr    = write_L1_L2;
        t.tag   = tag_L1_L2;
        t.idx   = index_L1_L2;
        t.grant = grant_o;
        return t;
    endfunction

    task automatic pop_exp(output txn_t e, output bit valid);
        valid = (exp_q.size() != 0);
        e = '0;
        if (valid) e = exp_q.pop_front();
    endtask

    task automatic clear_inputs();
        read_L1I_L2  = 1'b0;
        read_L1D_L2  = 1'b0;
        write_L1D_L2 = 1'b0;
        ready_L2_L1  = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        nrst = 1'b0;
        clear_inputs();
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    // Waits (bounded) for a grant, holds it lat cycles, then pulses ready.
    // Returns at the negedge after the ready pulse.
    task automatic capture(input int lat, output txn_t got, output int waited,
                           output logic rdy_i, output logic rdy_d);
        waited = 0;
        rdy_i  = 1'b0;
        rdy_d  = 1'b0;
        while (!(read_L1_L2 || write_L1_L2) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        got = cur_txn();
        if (!(read_L1_L2 || write_L1_L2)) begin
            waited = -1;
            return;
        end
        repeat (lat - 1) @(negedge clk);
        ready_L2_L1 = 1'b1;
        #1;
        rdy_i = ready_L2_L1I;
        rdy_d = ready_L2_L1D;
        @(negedge clk);
        ready_L2_L1 = 1'b0;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        read_L1I_L2 = 1'b1; read_L1D_L2 = 1'b1; write_L1D_L2 = 1'b1; ready_L2_L1 = 1'b1;
        tag_L1I_L2 = 22'h3FFFFF; index_L1I_L2 = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if ({read_L1_L2, write_L1_L2, tag_L1_L2, index_L1_L2, grant_o, timeout_o,
                 ready_L2_L1I, ready_L2_L1D} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs cycle %0d: rd=%b wr=%b tag=%h idx=%h grant=%b to=%b rdyI=%b rdyD=%b, required all 0",
                         i, read_L1_L2, write_L1_L2, tag_L1_L2, index_L1_L2, grant_o, timeout_o,
                         ready_L2_L1I, ready_L2_L1D);
            end
        end
        clear_inputs();
        nrst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_l1i_alone();
        txn_t e, g;
        bit   v;
        read_L1I_L2 = 1'b1; tag_L1I_L2 = 22'h1234; index_L1I_L2 = 4'd3;
        exp_q.push_back('{wr: 1'b0, tag: 22'h1234, idx: 4'd3, grant: 2'b01});
        @(negedge clk); // c1
        n_tests++;
        if (read_L1_L2 !== 1'b1 || write_L1_L2 !== 1'b0) begin
            n_fail++;
            $display("FAIL l1i_latency: rd=%b wr=%b, required rd=1 wr=0", read_L1_L2, write_L1_L2);
        end
        g = cur_txn();
        pop_exp(e, v);
        n_tests++;
        if (!v || g !== e) begin
            n_fail++;
            $display("FAIL l1i_txn: got %h, required %h (valid=%0d)", g, e, v);
        end
        for (int c = 2; c <= 4; c++) begin
            @(negedge clk);
            n_tests++;
            if (ready_L2_L1I !== 1'b0 || read_L1_L2 !== 1'b1) begin
                n_fail++;
                $display("FAIL l1i_hold c%0d: rdyI=%b rd=%b, required rdyI=0 rd=1", c, ready_L2_L1I, read_L1_L2);
            end
        end
        @(negedge clk); // c5
        ready_L2_L1 = 1'b1;
        #1;
        n_tests++;
        if (ready_L2_L1I !== 1'b1 || ready_L2_L1D !== 1'b0) begin
            n_fail++;
            $display("FAIL l1i_ready_route: rdyI=%b rdyD=%b, required 1/0", ready_L2_L1I, ready_L2_L1D);
        end
        @(negedge clk); // c6
        ready_L2_L1 = 1'b0;
        read_L1I_L2 = 1'b0;
        n_tests++;
        if (read_L1_L2 !== 1'b0 || grant_o !== 2'b00 || ready_L2_L1I !== 1'b0) begin
            n_fail++;
            $display("FAIL l1i_release: rd=%b grant=%b rdyI=%b, required 0/00/0", read_L1_L2, grant_o, ready_L2_L1I);
        end
        @(negedge clk);
    endtask

    task automatic test_contention();
        txn_t e, g;
        bit   v;
        int   w;
        logic ri, rd;
        do_reset();
        read_L1I_L2 = 1'b1; tag_L1I_L2 = 22'h2AAAA; index_L1I_L2 = 4'd1;
        read_L1D_L2 = 1'b1; tag_L1D_L2 = 22'h15555; index_L1D_L2 = 4'd2;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) exp_q.push_back('{wr: 1'b0, tag: 22'h15555, idx: 4'd2, grant: 2'b10});
            else            exp_q.push_back('{wr: 1'b0, tag: 22'h2AAAA, idx: 4'd1, grant: 2'b01});
        end
        for (int k = 0; k < 4; k++) begin
            capture(2, g, w, ri, rd);
            n_tests++;
            if (w !== 1) begin
                n_fail++;
                $display("FAIL rr_latency grant %0d: waited %0d cycles, required 1", k, w);
            end
            pop_exp(e, v);
            n_tests++;
            if (!v || g !== e) begin
                n_fail++;
                $display("FAIL rr_order grant %0d: got %h, required %h", k, g, e);
            end
            n_tests++;
            if ({ri, rd} !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL rr_ready_route grant %0d: rdyI=%b rdyD=%b", k, ri, rd);
            end
            n_tests++;
            if (read_L1_L2 !== 1'b0 || write_L1_L2 !== 1'b0 || grant_o !== 2'b00) begin
                n_fail++;
                $display("FAIL rr_idle_gap grant %0d: rd=%b wr=%b grant=%b, required idle", k, read_L1_L2, write_L1_L2, grant_o);
            end
        end
        clear_inputs();
        @(negedge clk);
    endtask

    task automatic test_write_then_read();
        txn_t e, g;
        bit   v;
        int   w;
        logic ri, rd;
        write_L1D_L2 = 1'b1; write_tag_L1D_L2 = 22'h0AA; write_index_L1D_L2 = 4'd5;
        read_L1D_L2  = 1'b1; tag_L1D_L2 = 22'h0BB; index_L1D_L2 = 4'd7;
        exp_q.push_back('{wr: 1'b1, tag: 22'h0AA, idx: 4'd5, grant: 2'b10});
        exp_q.push_back('{wr: 1'b0, tag: 22'h0BB, idx: 4'd7, grant: 2'b10});
        for (int k = 0; k < 2; k++) begin
            capture(3, g, w, ri, rd);
            if (k == 0) write_L1D_L2 = 1'b0;
            else        read_L1D_L2  = 1'b0;
            n_tests++;
            if (w !== 1) begin
                n_fail++;
                $display("FAIL wb_latency txn %0d: waited %0d, required 1", k, w);
            end
            pop_exp(e, v);
            n_tests++;
            if (!v || g !== e || read_L1_L2 !== 1'b0 || write_L1_L2 !== 1'b0) begin
                n_fail++;
                $display("FAIL wb_txn %0d: got %h idle_rd=%b idle_wr=%b, required %h and idle after",
                         k, g, read_L1_L2, write_L1_L2, e);
            end
            n_tests++;
            if (ri !== 1'b0 || rd !== 1'b1) begin
                n_fail++;
                $display("FAIL wb_ready_route txn %0d: rdyI=%b rdyD=%b, required 0/1", k, ri, rd);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_stray_and_hold();
        txn_t e, g;
        bit   v;
        ready_L2_L1 = 1'b1;
        #1;
        n_tests++;
        if (ready_L2_L1I !== 1'b0 || ready_L2_L1D !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_ready: rdyI=%b rdyD=%b, required 0/0", ready_L2_L1I, ready_L2_L1D);
        end
        @(negedge clk);
        ready_L2_L1 = 1'b0;
        n_tests++;
        if (read_L1_L2 !== 1'b0 || write_L1_L2 !== 1'b0 || grant_o !== 2'b00) begin
            n_fail++;
            $display("FAIL stray_state: rd=%b wr=%b grant=%b, required idle", read_L1_L2, write_L1_L2, grant_o);
        end
        read_L1D_L2 = 1'b1; tag_L1D_L2 = 22'h3C3; index_L1D_L2 = 4'd4;
        exp_q.push_back('{wr: 1'b0, tag: 22'h3C3, idx: 4'd4, grant: 2'b10});
        @(negedge clk);
        g = cur_txn();
        pop_exp(e, v);
        n_tests++;
        if (!v || g !== e) begin
            n_fail++;
            $display("FAIL hold_txn: got %h, required %h", g, e);
        end
        tag_L1D_L2 = 22'h111; index_L1D_L2 = 4'd9; read_L1D_L2 = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_tests++;
            if (tag_L1_L2 !== 22'h3C3 || index_L1_L2 !== 4'd4 || read_L1_L2 !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_stable c%0d: tag=%h idx=%h rd=%b, required 3c3/4/1", c, tag_L1_L2, index_L1_L2, read_L1_L2);
            end
        end
        ready_L2_L1 = 1'b1;
        #1;
        n_tests++;
        if (ready_L2_L1D !== 1'b1 || ready_L2_L1I !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_ready_route: rdyD=%b rdyI=%b, required 1/0", ready_L2_L1D, ready_L2_L1I);
        end
        @(negedge clk);
        ready_L2_L1 = 1'b0;
        n_tests++;
        if (read_L1_L2 !== 1'b0 || tag_L1_L2 !== 22'h3C3 || timeout_o !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: rd=%b tag=%h to=%b, required 0/3c3/0", read_L1_L2, tag_L1_L2, timeout_o);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        txn_t e, g;
        bit   v;
        read_L1I_L2 = 1'b1; tag_L1I_L2 = 22'h0F0F0; index_L1I_L2 = 4'hA;
        exp_q.push_back('{wr: 1'b0, tag: 22'h0F0F0, idx: 4'hA, grant: 2'b01});
        @(negedge clk); // c1
        g = cur_txn();
        pop_exp(e, v);
        n_tests++;
        if (!v || g !== e) begin
            n_fail++;
            $display("FAIL to_txn: got %h, required %h", g, e);
        end
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) @(negedge clk);
            n_tests++;
            if (timeout_o !== 1'b0) begin
                n_fail++;
                $display("FAIL to_early c%0d: timeout=%b, required 0", c, timeout_o);
            end
        end
        for (int c = 9; c <= 12; c++) begin
            @(negedge clk);
            n_tests++;
            if (timeout_o !== 1'b1 || read_L1_L2 !== 1'b1 || grant_o !== 2'b01) begin
                n_fail++;
                $display("FAIL to_set c%0d: timeout=%b rd=%b grant=%b, required 1/1/01", c, timeout_o, read_L1_L2, grant_o);
            end
        end
        ready_L2_L1 = 1'b1;
        #1;
        n_tests++;
        if (ready_L2_L1I !== 1'b1) begin
            n_fail++;
            $display("FAIL to_ready: rdyI=%b, required 1", ready_L2_L1I);
        end
        @(negedge clk);
        ready_L2_L1 = 1'b0;
        read_L1I_L2 = 1'b0;
        n_tests++;
        if (read_L1_L2 !== 1'b0 || grant_o !== 2'b00 || timeout_o !== 1'b1) begin
            n_fail++;
            $display("FAIL to_sticky: rd=%b grant=%b timeout=%b, required 0/00/1", read_L1_L2, grant_o, timeout_o);
        end
        @(negedge clk);
        read_L1D_L2 = 1'b1; tag_L1D_L2 = 22'h777; index_L1D_L2 = 4'd6;
        exp_q.push_back('{wr: 1'b0, tag: 22'h777, idx: 4'd6, grant: 2'b10});
        @(negedge clk);
        g = cur_txn();
        pop_exp(e, v);
        n_tests++;
        if (!v || g !== e) begin
            n_fail++;
            $display("FAIL rst_mid_txn: got %h, required %h", g, e);
        end
        @(negedge clk);
        nrst = 1'b0;
        ready_L2_L1 = 1'b1;
        #1;
        n_tests++;
        if ({read_L1_L2, write_L1_L2, grant_o, timeout_o, ready_L2_L1I, ready_L2_L1D} !== 7'b0) begin
            n_fail++;
            $display("FAIL rst_mid_grant: rd=%b wr=%b grant=%b to=%b rdyI=%b rdyD=%b, required all 0",
                     read_L1_L2, write_L1_L2, grant_o, timeout_o, ready_L2_L1I, ready_L2_L1D);
        end
        @(negedge clk);
        clear_inputs();
        nrst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (read_L1_L2 !== 1'b0 || grant_o !== 2'b00 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL post_reset_idle: rd=%b grant=%b pending=%0d, required 0/00/0", read_L1_L2, grant_o, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_l1i_alone();
        test_contention();
        test_write_then_read();
        test_stray_and_hold();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
